// File: rtl/if_id_skid_reg.sv
// if_id_skid_reg: IF/ID pipeline register with one-entry skid buffer; define IF_ID_PERF_EN for bubble/flush counters
module if_id_skid_reg #(
    parameter int DW = 32,
    parameter logic [DW-1:0] NOP_WORD = '0
) (
    input  logic          clk,
    input  logic          arst,
    input  logic          f_valid,
    output logic          f_ready,
    input  logic [DW-1:0] f_pc4,
    input  logic [DW-1:0] f_instr,
    output logic          d_valid,
    input  logic          d_ready,
    output logic [DW-1:0] d_pc4,
    output logic [DW-1:0] d_instr,
    input  logic          stall,
    input  logic          flush
`ifdef IF_ID_PERF_EN
    ,
    output logic [15:0]   bubble_cnt,
    output logic [15:0]   flush_cnt
`endif
);
    logic          main_valid, skid_valid;
    logic [DW-1:0] main_pc4, main_instr, skid_pc4, skid_instr;
    logic          accept, consume, main_free;

    assign accept    = f_valid & f_ready;
    assign consume   = main_valid & d_ready & !stall;
    assign main_free = !main_valid | consume;
    assign f_ready   = !skid_valid;
    assign d_valid   = main_valid;
    assign d_pc4     = main_pc4;
    assign d_instr   = main_valid ? main_instr : NOP_WORD;

    always_ff @(posedge clk) begin
        if (arst) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_pc4   <= '0;
            main_instr <= NOP_WORD;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (main_free) begin
            if (skid_valid) begin
                main_valid <= 1'b1;
                main_pc4   <= skid_pc4;
                main_instr <= skid_instr;
                skid_valid <= accept;
            end else begin
                main_valid <= accept;
                if (accept) begin
                    main_pc4   <= f_pc4;
                    main_instr <= f_instr;
                end
            end
        end else if (accept) begin
            skid_valid <= 1'b1;
        end
    end

    // Skid data is only meaningful while skid_valid is set, so it needs no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            skid_pc4   <= f_pc4;
            skid_instr <= f_instr;
        end
    end

`ifdef IF_ID_PERF_EN
    always_ff @(posedge clk) begin
        if (arst) begin
            bubble_cnt <= '0;
            flush_cnt  <= '0;
        end else begin
            if ((!main_valid || stall) && bubble_cnt != 16'hFFFF) bubble_cnt <= bubble_cnt + 16'd1;
            if (flush && flush_cnt != 16'hFFFF) flush_cnt <= flush_cnt + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_if_id_skid_reg.sv
// tb_if_id_skid_reg: scoreboard bench for if_id_skid_reg with directed handshake, stall, flush and reset vectors
module tb_if_id_skid_reg;
    logic        clk = 1'b0;
    logic        arst, f_valid, d_ready, stall, flush;
    logic        f_ready, d_valid;
    logic [31:0] f_pc4, f_instr, d_pc4, d_instr;
`ifdef IF_ID_PERF_EN
    logic [15:0] bubble_cnt, flush_cnt;
`endif
    int errors = 0;
    int checks = 0;
    logic [63:0] exp_q[$];

    localparam logic [31:0] K = 32'hA5A5_0000;

    if_id_skid_reg dut (
        .clk(clk), .arst(arst),
        .f_valid(f_valid), .f_ready(f_ready), .f_pc4(f_pc4), .f_instr(f_instr),
        .d_valid(d_valid), .d_ready(d_ready), .d_pc4(d_pc4), .d_instr(d_instr),
        .stall(stall), .flush(flush)
`ifdef IF_ID_PERF_EN
        , .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [31:0] pc, input logic [31:0] ins);
        f_valid = 1'b1;
        f_pc4   = pc;
        f_instr = ins;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: sees the inputs that the next rising edge will apply.
    always @(negedge clk) begin
        logic [63:0] e;
        if (arst || flush) begin
            exp_q.delete();
        end else begin
            if (d_valid && d_ready && !stall) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_extra: got pc4 %h with nothing expected", d_pc4);
                end else begin
                    e = exp_q.pop_front();
                    if ({d_pc4, d_instr} !== e) begin
                        errors++;
                        $display("FAIL sb_beat: got %h/%h expected %h/%h", d_pc4, d_instr, e[63:32], e[31:0]);
                    end
                end
            end
            if (f_valid && f_ready) exp_q.push_back({f_pc4, f_instr});
        end
        if (!d_valid) begin
            checks++;
            if (d_instr !== 32'h0) begin
                errors++;
                $display("FAIL nop_when_invalid: got %h expected 00000000", d_instr);
            end
        end
    end

    initial begin
        arst = 1'b1; f_valid = 1'b0; d_ready = 1'b0; stall = 1'b0; flush = 1'b0;
        f_pc4 = '0; f_instr = '0;
        cyc(); cyc();
        chk("rst_d_valid", {31'd0, d_valid}, 32'd0);
        chk("rst_d_pc4", d_pc4, 32'd0);
        chk("rst_d_instr", d_instr, 32'd0);
        chk("rst_f_ready", {31'd0, f_ready}, 32'd1);
        arst = 1'b0;

        // stream
        d_ready = 1'b1;
        beat(32'h4, 32'h4 ^ K); cyc();
        chk("str_v0", {31'd0, d_valid}, 32'd1);
        chk("str_pc0", d_pc4, 32'h4);
        beat(32'h8, 32'h8 ^ K); cyc();
        chk("str_pc1", d_pc4, 32'h8);
        chk("str_rdy", {31'd0, f_ready}, 32'd1);
        beat(32'hC, 32'hC ^ K); cyc();
        chk("str_pc2", d_pc4, 32'hC);
        f_valid = 1'b0; cyc();
        chk("str_drain", {31'd0, d_valid}, 32'd0);

        // backpressure
        d_ready = 1'b0;
        beat(32'h4, 32'h1111_0004); cyc();
        beat(32'h8, 32'h1111_0008); cyc();
        chk("bp_f_ready", {31'd0, f_ready}, 32'd0);
        chk("bp_hold", d_pc4, 32'h4);
        f_valid = 1'b0; d_ready = 1'b1; cyc();
        chk("bp_skid2main", d_pc4, 32'h8);
        chk("bp_f_ready1", {31'd0, f_ready}, 32'd1);
        cyc();
        chk("bp_empty", {31'd0, d_valid}, 32'd0);

        // stall holds the beat; a second beat fills skid meanwhile
        d_ready = 1'b0;
        beat(32'h10, 32'h8C22_0004); cyc();
        f_valid = 1'b0; stall = 1'b1; d_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (i == 1) beat(32'h14, 32'h0000_0014);
            cyc();
            f_valid = 1'b0;
            chk("stall_pc", d_pc4, 32'h10);
            chk("stall_instr", d_instr, 32'h8C22_0004);
        end
        chk("stall_f_ready", {31'd0, f_ready}, 32'd0);
        stall = 1'b0; cyc();
        chk("stall_rel", d_pc4, 32'h14);
        cyc();
        chk("stall_once", {31'd0, d_valid}, 32'd0);

        // flush with both entries full plus an incoming beat
        d_ready = 1'b0;
        beat(32'h4, 32'h2222_0004); cyc();
        beat(32'h8, 32'h2222_0008); cyc();
        beat(32'hC, 32'h2222_000C); flush = 1'b1; d_ready = 1'b1; cyc();
        chk("fl_d_valid", {31'd0, d_valid}, 32'd0);
        chk("fl_d_instr", d_instr, 32'd0);
        chk("fl_f_ready", {31'd0, f_ready}, 32'd1);
        flush = 1'b0;
        beat(32'h40, 32'h2222_0040); cyc();
        chk("fl_next", d_pc4, 32'h40);
        f_valid = 1'b0; cyc();
        chk("fl_no_stale", {31'd0, d_valid}, 32'd0);

        // flush drops a beat accepted in the same cycle
        d_ready = 1'b0;
        beat(32'h50, 32'h3333_0050); cyc();
        beat(32'h54, 32'h3333_0054); flush = 1'b1; cyc();
        flush = 1'b0; f_valid = 1'b0; cyc();
        chk("fl_drop", {31'd0, d_valid}, 32'd0);
`ifdef IF_ID_PERF_EN
        chk("perf_flush", {16'd0, flush_cnt}, 32'd2);
`endif

        // mid-operation reset with skid full under stall
        stall = 1'b1;
        beat(32'h60, 32'h4444_0060); cyc();
        beat(32'h64, 32'h4444_0064); cyc();
        chk("mr_full", {31'd0, f_ready}, 32'd0);
        f_valid = 1'b0; arst = 1'b1; cyc();
        chk("mr_d_valid", {31'd0, d_valid}, 32'd0);
        chk("mr_f_ready", {31'd0, f_ready}, 32'd1);
        chk("mr_d_pc4", d_pc4, 32'd0);
        chk("mr_d_instr", d_instr, 32'd0);
`ifdef IF_ID_PERF_EN
        chk("mr_bubble", {16'd0, bubble_cnt}, 32'd0);
        chk("mr_flush", {16'd0, flush_cnt}, 32'd0);
`endif
        arst = 1'b0; stall = 1'b0; d_ready = 1'b1;
        cyc(); cyc();
        chk("mr_stay_empty", {31'd0, d_valid}, 32'd0);
        chk("sb_leftover", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/if_id_skid_reg.md
Name: if_id_skid_reg

Overview:
- Pipeline register between the fetch stage and the decode stage of the pipelined MIPS core.
- Captures the fetched PC+4 and instruction word under a valid/ready handshake.
- Contains a one-entry skid buffer so the fetch-side ready is a registered signal and never depends combinationally on decode-side ready.
- Takes a hold (stall) request from the hazard unit and a flush request from branch resolution; a flush turns any held beat into a bubble.

Parameters:
- DW, 32, width of the PC and instruction fields
- NOP_WORD, 32'h00000000, instruction value driven on d_instr whenever the output is invalid (sll $0,$0,0)

Ports:
- clk  input  1  clock; all state updates on the rising edge
- arst  input  1  synchronous, active-high reset; sampled only on the clk rising edge (the name follows the codebase port naming)
- f_valid  input  1  fetch presents a beat
- f_ready  output  1  register can accept a beat; registered, equals !skid_valid
- f_pc4  input  DW  PC+4 of the fetched instruction
- f_instr  input  DW  fetched instruction word
- d_valid  output  1  decode-side beat valid (main entry valid)
- d_ready  input  1  decode accepts the beat
- d_pc4  output  DW  main entry PC+4
- d_instr  output  DW  main entry instruction; NOP_WORD when d_valid=0
- stall  input  1  hazard-unit hold; blocks consumption like d_ready=0
- flush  input  1  branch/jump redirect; discards all held and incoming beats

Behaviour:
- Reset (arst=1 at an edge):
  - main_valid=0, skid_valid=0, d_pc4=0, d_instr=NOP_WORD.
  - f_ready=1 from the first edge after arst deasserts.
  - Reset overrides flush, stall and any in-flight beat.
- Handshake definitions:
  - Accept: accept = f_valid & f_ready.
  - Consume: consume = d_valid & d_ready & !stall.
- Latency: an accepted beat appears on d_* on the next edge when main is empty or being consumed. Otherwise it lands in skid and reaches d_* one edge after main drains.
- Per-edge update (flush=0):
  - main empty or consume, skid valid: skid -> main; the incoming beat (if accept) -> skid.
  - main empty or consume, skid empty: incoming beat (if accept) -> main; else main_valid <= 0.
  - main held (valid and not consumed), accept: incoming beat -> skid. f_ready drops to 0 the next cycle.
  - main held, no accept: no change.
- Flush (flush=1 at an edge):
  - main_valid and skid_valid <= 0 and d_instr <= NOP_WORD.
  - Any beat accepted in that cycle is dropped.
  - Flush has priority over stall and d_ready.
  - f_ready is 1 the next cycle.
- Stall together with f_valid: the beat fills skid if empty; fetch then sees f_ready=0 until main drains.
- Ordering: beats leave in acceptance order. No beat is duplicated or dropped except by flush or reset.
- Data fields of empty entries are don't-care internally. d_instr is forced to NOP_WORD whenever d_valid=0, so decode never sees a stale instruction.
- f_ready=0 implies both entries are full. Two-deep is the maximum; there is no overflow path.

Optional Feature:
- Macro IF_ID_PERF_EN.
- Defined:
  - Adds output bubble_cnt [15:0]: increments on each edge where d_valid=0 or stall=1, excluding reset.
  - Adds output flush_cnt [15:0]: increments on each flush edge.
  - Both clear on arst and saturate at 16'hFFFF.
- Undefined: no counters and no extra ports; the core behaviour is identical.

Test Plan:
- Reset then stream: arst=1 for 2 edges, then f_valid=1 with pc4=0x4,0x8,0xC and d_ready=1 -> d_valid rises one edge after each accept, d_pc4 = 0x4,0x8,0xC on consecutive cycles, f_ready stays 1.
- Backpressure: main holds 0x4, d_ready=0, accept 0x8 -> skid full, f_ready=0. Then d_ready=1 -> d_pc4=0x4 consumed, then 0x8 next cycle, f_ready=1 after skid empties.
- Stall: stall=1 for 3 cycles with d_ready=1 and main=0x10/instr 0x8C220004 -> d_* held constant, no consume. Release -> 0x10 consumed exactly once.
- Flush with both entries full plus an incoming beat: flush=1 one edge -> d_valid=0, d_instr=0x00000000, f_ready=1. The next beat 0x40 appears alone, with no stale 0x8.
- Mid-operation reset: skid full, arst=1 during stall=1 and flush=0 -> next edge all valids 0 and d_pc4=0. With IF_ID_PERF_EN, bubble_cnt=0 and flush_cnt=0.
